// File: rtl/apb_timer_slave.sv
// APB slave with a prescaled down-counter timer and level interrupt.
// Define APB_TIMER_WAIT_EN to enable the WAIT_STATES access-phase wait counter.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_timer_slave #(
    parameter int CNT_WIDTH      = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int WAIT_STATES    = 1
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [`PADDR_WIDTH-1:0]    paddr,
    input  logic [`APB_DATA_WIDTH-1:0] pwdata,
    output logic [`APB_DATA_WIDTH-1:0] prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic                       irq
);
    localparam int DW = `APB_DATA_WIDTH;

    logic                      access_s;
    logic                      ready_s;
    logic                      err_s;
    logic                      commit_s;
    logic [2:0]                idx_s;
    logic                      wr_ctrl_s;
    logic                      wr_load_s;
    logic                      wr_pre_s;
    logic                      wr_status_s;
    logic                      tick_s;
    logic                      expire_s;
    logic [DW-1:0]             rdata_s;
    logic                      unused_s;

    logic                      en_r;
    logic                      reload_r;
    logic                      irq_en_r;
    logic [CNT_WIDTH-1:0]      load_r;
    logic [CNT_WIDTH-1:0]      value_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] pcnt_r;
    logic                      timeout_r;
    logic                      irq_r;

    assign access_s = psel & penable;
    assign idx_s    = paddr[4:2];
    assign unused_s = ^{paddr, pwdata};

`ifdef APB_TIMER_WAIT_EN
    localparam logic [3:0] WAIT_CFG = 4'(WAIT_STATES);
    logic [3:0] wait_cnt_r;

    // Wait counter restarts outside the access phase and after each completion
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wait_cnt_r <= 4'd0;
        end else if (!access_s || ready_s) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end

    assign ready_s = access_s && (wait_cnt_r == WAIT_CFG);
`else
    logic unused_wait_s;
    assign unused_wait_s = (WAIT_STATES == 0);
    assign ready_s       = access_s;
`endif

    assign err_s       = (idx_s > 3'd4) || (pwrite && (idx_s == 3'd2));
    assign commit_s    = ready_s && pwrite && !err_s;
    assign wr_ctrl_s   = commit_s && (idx_s == 3'd0);
    assign wr_load_s   = commit_s && (idx_s == 3'd1);
    assign wr_pre_s    = commit_s && (idx_s == 3'd3);
    assign wr_status_s = commit_s && (idx_s == 3'd4);

    assign tick_s   = en_r && (pcnt_r == prescale_r);
    assign expire_s = tick_s && (value_r == '0);

    // Register read multiplexer
    always_comb begin
        rdata_s = '0;
        case (idx_s)
            3'd0:    rdata_s[2:0] = {irq_en_r, reload_r, en_r};
            3'd1:    rdata_s[CNT_WIDTH-1:0] = load_r;
            3'd2:    rdata_s[CNT_WIDTH-1:0] = value_r;
            3'd3:    rdata_s[PRESCALE_WIDTH-1:0] = prescale_r;
            3'd4:    rdata_s[0] = timeout_r;
            default: rdata_s = '0;
        endcase
    end

    assign pready  = ready_s;
    assign pslverr = ready_s && err_s;
    assign prdata  = (ready_s && !pwrite && !err_s) ? rdata_s : '0;
    assign irq     = irq_r;

    // Control bits and prescaler; enabling from idle restarts the prescale phase
    always_ff @(posedge hclk) begin
        if (hreset) begin
            en_r     <= 1'b0;
            reload_r <= 1'b0;
            irq_en_r <= 1'b0;
            pcnt_r   <= '0;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= pwdata[0];
                reload_r <= pwdata[1];
                irq_en_r <= pwdata[2];
            end else if (expire_s && !reload_r) begin
                en_r <= 1'b0;
            end else begin
                en_r <= en_r;
            end
            if (wr_ctrl_s && pwdata[0] && !en_r) begin
                pcnt_r <= '0;
            end else if (tick_s) begin
                pcnt_r <= '0;
            end else if (en_r) begin
                pcnt_r <= pcnt_r + PRESCALE_WIDTH'(1);
            end else begin
                pcnt_r <= pcnt_r;
            end
        end
    end

    // LOAD, PRESCALE and the down-counter; a LOAD write overrides the tick
    always_ff @(posedge hclk) begin
        if (hreset) begin
            load_r     <= '0;
            value_r    <= '0;
            prescale_r <= '0;
        end else begin
            if (wr_load_s) begin
                load_r  <= pwdata[CNT_WIDTH-1:0];
                value_r <= pwdata[CNT_WIDTH-1:0];
            end else if (tick_s && (value_r != '0)) begin
                value_r <= value_r - CNT_WIDTH'(1);
            end else if (expire_s && reload_r) begin
                value_r <= load_r;
            end else begin
                value_r <= value_r;
            end
            if (wr_pre_s) begin
                prescale_r <= pwdata[PRESCALE_WIDTH-1:0];
            end else begin
                prescale_r <= prescale_r;
            end
        end
    end

    // Timeout flag (set beats clear) and the registered interrupt
    always_ff @(posedge hclk) begin
        if (hreset) begin
            timeout_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (expire_s) begin
                timeout_r <= 1'b1;
            end else if (wr_status_s && pwdata[0]) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
            irq_r <= timeout_r & irq_en_r;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave against a behavioural timer model.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module tb_apb_timer_slave;
    localparam int WS = 1;
`ifdef APB_TIMER_WAIT_EN
    localparam int EXP_WAIT = WS;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [`PADDR_WIDTH-1:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic        m_en, m_reload, m_irqen, m_timeout, m_irq;
    logic [31:0] m_load, m_value;
    logic [7:0]  m_pre, m_pcnt;

    logic [31:0] rd;
    logic        er;

    always #5 hclk = ~hclk;

    apb_timer_slave #(
        .CNT_WIDTH(32),
        .PRESCALE_WIDTH(8),
        .WAIT_STATES(WS)
    ) dut (
        .hclk(hclk),
        .hreset(hreset),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {29'd0, m_irqen, m_reload, m_en};
            3'd1:    return m_load;
            3'd2:    return m_value;
            3'd3:    return {24'd0, m_pre};
            3'd4:    return {31'd0, m_timeout};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer as the register description states it
    task automatic model_edge(input logic rst, input logic cm, input logic [2:0] ci, input logic [31:0] cd);
        logic tick, expire;
        logic n_en, n_reload, n_irqen, n_timeout, n_irq;
        logic [31:0] n_load, n_value;
        logic [7:0] n_pre, n_pcnt;
        if (rst) begin
            {m_en, m_reload, m_irqen, m_timeout, m_irq} = 5'd0;
            m_load = 32'd0; m_value = 32'd0; m_pre = 8'd0; m_pcnt = 8'd0;
        end else begin
            tick   = m_en && (m_pcnt == m_pre);
            expire = tick && (m_value == 32'd0);
            n_en = m_en; n_reload = m_reload; n_irqen = m_irqen; n_timeout = m_timeout;
            n_load = m_load; n_value = m_value; n_pre = m_pre; n_pcnt = m_pcnt;
            n_irq = m_timeout && m_irqen;
            if (m_en) n_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
            if (tick) begin
                if (m_value != 32'd0) n_value = m_value - 32'd1;
                else begin
                    n_timeout = 1'b1;
                    if (m_reload) n_value = m_load;
                    else n_en = 1'b0;
                end
            end
            if (cm) begin
                case (ci)
                    3'd0: begin
                        n_en = cd[0]; n_reload = cd[1]; n_irqen = cd[2];
                        if (cd[0] && !m_en) n_pcnt = 8'd0;
                    end
                    3'd1: begin n_load = cd; n_value = cd; end
                    3'd3: n_pre = cd[7:0];
                    3'd4: if (cd[0] && !expire) n_timeout = 1'b0;
                    default: ;
                endcase
            end
            m_en = n_en; m_reload = n_reload; m_irqen = n_irqen; m_timeout = n_timeout;
            m_irq = n_irq; m_load = n_load; m_value = n_value; m_pre = n_pre; m_pcnt = n_pcnt;
        end
    endtask

    task automatic step(input logic cm, input logic [2:0] ci, input logic [31:0] cd);
        check("irq", irq, m_irq);
        @(posedge hclk);
        model_edge(hreset, cm, ci, cd);
        @(negedge hclk);
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 32'd0);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic ero);
        logic [2:0]  idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        bit          done;
        done    = 1'b0;
        idx     = addr[4:2];
        exp_err = (idx > 3'd4) || (wr && (idx == 3'd2));
        rdo = 32'd0; ero = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        #1 check("setup_pready", pready, 1'b0);
        step(1'b0, 3'd0, 32'd0);
        penable = 1'b1;
        for (int i = 0; i <= EXP_WAIT + 2 && !done; i++) begin
            #1;
            check("pready", pready, (i == EXP_WAIT));
            if (pready) begin
                exp_rd = (exp_err || wr) ? 32'd0 : m_read(idx);
                rdo = prdata; ero = pslverr;
                check("pslverr", pslverr, exp_err);
                if (!wr) check("prdata", prdata, exp_rd);
                step(wr && !exp_err, idx, wd);
                done = 1'b1;
            end else begin
                check("wait_prdata", prdata, 32'd0);
                step(1'b0, 3'd0, 32'd0);
            end
        end
        check("pready_timeout", done, 1'b1);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = 32'd0;
        @(negedge hclk);
        step(1'b0, 3'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0);
        hreset = 1'b0;
        #1;
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_irq", irq, 1'b0);
        for (int r = 0; r < 5; r++) begin
            xfer(1'b0, 32'(r * 4), 32'd0, rd, er);
            check("rst_reg", rd, 32'd0);
        end

        // one-shot countdown with interrupt
        xfer(1'b1, 32'h04, 32'd3, rd, er);
        xfer(1'b1, 32'h0C, 32'd0, rd, er);
        xfer(1'b1, 32'h00, 32'h5, rd, er);
        for (int r = 0; r < 6; r++) xfer(1'b0, 32'h08, 32'd0, rd, er);
        idle(2);
        xfer(1'b0, 32'h10, 32'd0, rd, er);
        check("oneshot_timeout", rd, 32'd1);
        check("oneshot_irq", irq, 1'b1);
        xfer(1'b0, 32'h00, 32'd0, rd, er);
        check("oneshot_en_clr", rd, 32'h4);

        // reload with prescale 2
        xfer(1'b1, 32'h10, 32'd1, rd, er);
        xfer(1'b1, 32'h04, 32'd2, rd, er);
        xfer(1'b1, 32'h0C, 32'd2, rd, er);
        xfer(1'b1, 32'h00, 32'h7, rd, er);
        for (int r = 0; r < 10; r++) xfer(1'b0, 32'h08, 32'd0, rd, er);
        xfer(1'b0, 32'h10, 32'd0, rd, er);
        check("reload_timeout", rd, 32'd1);

        // clear colliding with a timeout: set wins
        xfer(1'b1, 32'h00, 32'h0, rd, er);
        xfer(1'b1, 32'h10, 32'd1, rd, er);
        xfer(1'b1, 32'h04, 32'd6, rd, er);
        xfer(1'b1, 32'h0C, 32'd0, rd, er);
        xfer(1'b1, 32'h00, 32'h7, rd, er);
        for (int k = 0; k < 40 && m_value != 32'(1 + EXP_WAIT); k++) step(1'b0, 3'd0, 32'd0);
        check("align_value", m_value, 32'(1 + EXP_WAIT));
        xfer(1'b1, 32'h10, 32'd1, rd, er);
        xfer(1'b0, 32'h10, 32'd0, rd, er);
        check("set_wins", rd, 32'd1);
        xfer(1'b1, 32'h00, 32'h4, rd, er);
        xfer(1'b1, 32'h10, 32'd1, rd, er);
        check("irq_lag", irq, 1'b1);
        step(1'b0, 3'd0, 32'd0);
        check("irq_drop", irq, 1'b0);
        xfer(1'b0, 32'h10, 32'd0, rd, er);
        check("status_clr", rd, 32'd0);

        // error responses
        xfer(1'b1, 32'h14, 32'hFFFF, rd, er);
        check("err_wr14", er, 1'b1);
        xfer(1'b1, 32'h08, 32'hFF, rd, er);
        check("err_wrval", er, 1'b1);
        xfer(1'b0, 32'h18, 32'd0, rd, er);
        check("err_rd18_data", rd, 32'd0);
        check("err_rd18", er, 1'b1);
        xfer(1'b0, 32'h08, 32'd0, rd, er);
        xfer(1'b0, 32'h04, 32'd0, rd, er);

        // reset during the access phase of a LOAD write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hAA;
        step(1'b0, 3'd0, 32'd0);
        penable = 1'b1; hreset = 1'b1;
        step(1'b0, 3'd0, 32'd0);
        hreset = 1'b0; psel = 1'b0; penable = 1'b0;
        #1 check("rst_mid_pready", pready, 1'b0);
        xfer(1'b0, 32'h04, 32'd0, rd, er);
        check("rst_mid_load", rd, 32'd0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  idx;
            logic        wr;
            logic [31:0] d;
            idx = 3'($urandom_range(0, 6));
            wr  = 1'($urandom_range(0, 1));
            case (idx)
                3'd0:    d = {29'd0, 3'($urandom_range(0, 7)) | 3'b001};
                3'd1:    d = 32'($urandom_range(0, 6));
                3'd3:    d = 32'($urandom_range(0, 3));
                default: d = 32'($urandom_range(0, 1));
            endcase
            xfer(wr, {27'd0, idx, 2'b00}, d, rd, er);
            idle($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
